// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter.
//   state_t          - arbiter FSM encoding (IDLE, BUSY_I, BUSY_D, RESP)
//   DEF_TIMEOUT      - default BUSY-cycle budget before an access is aborted
//   DEF_STARVE_MAX   - default number of data-side wins before fetch is forced
//   cnt_width()      - bits needed to hold the values 0..max_val
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_STARVE_MAX = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter.
//   if_*   - instruction-fetch requester (req/addr in, ready/rdata out)
//   dm_*   - data requester (req/we/addr/wdata in, ready/rdata out)
//   mem_*  - single-port memory (req/we/addr/wdata out, ack/rdata in)
// Modports:
//   slave  - the arbiter's view (serves both requesters, drives memory)
//   master - the surrounding system's view (requesters plus memory model)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_timer.sv
// arb_timer: loadable up-counter with a terminal flag.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - load load_val on the next edge (has priority over en)
//   load_val   - value loaded by load
//   en         - count up by one per cycle; holds once the terminal is reached
//   done       - combinational, high while the count equals LIMIT
module arb_timer #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && !done) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign done = (count_reg == WIDTH'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester and a data requester. Data normally wins; after STARVE_MAX
// consecutive data wins with fetch waiting, fetch is forced through. An
// access with no mem_ack for TIMEOUT BUSY cycles is aborted with rdata=0 and
// the sticky err flag set.
//   clk, rst_n   - clock, synchronous active-low reset
//   bus          - requester/memory signals (mem_arbiter_if.slave)
//   c_stall_if   - fetch stage stall  (if_req & ~if_ready)
//   c_stall_mem  - MEM stage stall    (dm_req & ~dm_ready)
//   err          - sticky timeout flag, cleared only by reset
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic         c_stall_if,
    output logic         c_stall_mem,
    output logic         err
);
    localparam int SW = cnt_width(STARVE_MAX);
    localparam int TW = cnt_width(TIMEOUT);

    state_t            state_reg, state_next;
    logic [SW-1:0]     starve_cnt_reg;
    logic              grant_i, grant_d;
    logic              acked, timed_out;
    logic              in_busy, tmr_done;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] resp_data;

    assign in_busy = (state_reg == BUSY_I) || (state_reg == BUSY_D);

    // Restarted on every grant; done fires in the TIMEOUT-th BUSY cycle.
    arb_timer #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT - 1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant_i | grant_d),
        .load_val ('0),
        .en       (in_busy),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Data wins unless fetch is waiting and has been starved long enough.
                if (bus.dm_req && !(bus.if_req && starve_cnt_reg == SW'(STARVE_MAX))) begin
                    grant_d = 1'b1;
                end else if (bus.if_req) begin
                    grant_i = 1'b1;
                end
                if (grant_i) begin
                    state_next = BUSY_I;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack arriving in the timeout cycle still completes normally.
                if (bus.mem_ack) begin
                    acked      = 1'b1;
                    state_next = RESP;
                end else if (tmr_done) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_addr = grant_i ? bus.if_addr : bus.dm_addr;
    // Writes and aborted accesses return zero.
    assign resp_data  = (acked && !bus.mem_we) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.if_ready   <= 1'b0;
            bus.if_rdata   <= '0;
            bus.dm_ready   <= 1'b0;
            bus.dm_rdata   <= '0;
            err            <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;

            // The transaction is frozen here; requester inputs are ignored until RESP.
            if (grant_i || grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= grant_d & bus.dm_we;
                bus.mem_addr  <= grant_addr;
                bus.mem_wdata <= grant_d ? bus.dm_wdata : '0;
            end

            if (acked || timed_out) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
                if (state_reg == BUSY_D) begin
                    bus.dm_ready <= 1'b1;
                    bus.dm_rdata <= resp_data;
                end else begin
                    bus.if_ready <= 1'b1;
                    bus.if_rdata <= resp_data;
                end
            end

            // rdata is only meaningful alongside ready; clear it on the way out.
            if (state_reg == RESP) begin
                bus.if_rdata <= '0;
                bus.dm_rdata <= '0;
            end

            if (timed_out) begin
                err <= 1'b1;
            end

            if (grant_i) begin
                starve_cnt_reg <= '0;
            end else if (grant_d && bus.if_req && starve_cnt_reg != SW'(STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + SW'(1);
            end
        end
    end

    assign c_stall_if  = bus.if_req & ~bus.if_ready;
    assign c_stall_mem = bus.dm_req & ~bus.dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A table of single transactions is applied in a loop; hand-written sequences
// cover arbitration order, starvation, timeout, reset mid-access and stray acks.
// Expected grants and responses are queued when a request is driven and popped
// by a monitor when the arbiter raises mem_req or a ready pulse.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clk;
    logic rst_n;
    logic c_stall_if;
    logic c_stall_mem;
    logic err;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .c_stall_if  (c_stall_if),
        .c_stall_mem (c_stall_mem),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        side_d;
        logic [31:0] rdata;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    // ---------------- memory responder ----------------
    bit ack_enable = 1'b1;
    int ack_lat    = 0;

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_enable) begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req) begin
                    if (wait_cnt >= ack_lat) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_word(bus.mem_addr);
                        wait_cnt      = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic   prev_req;
        grant_t g;
        resp_t  r;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            chk("stall_if_eq",  32'(c_stall_if),  32'(bus.if_req & ~bus.if_ready));
            chk("stall_mem_eq", 32'(c_stall_mem), 32'(bus.dm_req & ~bus.dm_ready));
            if (bus.mem_req && !prev_req) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 32'(1), 32'(0));
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_we",    32'(bus.mem_we), 32'(g.we));
                    chk("grant_addr",  bus.mem_addr,    g.addr);
                    chk("grant_wdata", bus.mem_wdata,   g.wdata);
                end
            end
            prev_req = bus.mem_req;
            if (bus.if_ready || bus.dm_ready) begin
                chk("one_ready", 32'(bus.if_ready & bus.dm_ready), 32'(0));
                if (resp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(1), 32'(0));
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_side", 32'(bus.dm_ready), 32'(r.side_d));
                    chk("resp_rdata", r.side_d ? bus.dm_rdata : bus.if_rdata, r.rdata);
                    $display("tx side=%s rdata=0x%08h err=%0b t=%0t",
                             r.side_d ? "dm" : "if",
                             r.side_d ? bus.dm_rdata : bus.if_rdata, err, $time);
                end
            end
        end
    end

    // ---------------- single-transaction driver ----------------
    task automatic do_req(input logic side_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input int exp_cycles,
                          input logic [31:0] exp_rdata, input bit ackon);
        grant_t g;
        resp_t  r;
        int     cyc;
        bit     got;
        ack_lat    = lat;
        ack_enable = ackon;
        g.we    = side_d & we;
        g.addr  = addr;
        g.wdata = side_d ? wdata : 32'h0;
        grant_q.push_back(g);
        r.side_d = side_d;
        r.rdata  = exp_rdata;
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        if (side_d) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (side_d ? bus.dm_ready : bus.if_ready) got = 1'b1;
            // After the grant edge: change inputs, the latched access must not follow.
            if (cyc == 2) begin
                if (side_d) begin
                    bus.dm_we = ~we; bus.dm_addr = ~addr; bus.dm_wdata = ~wdata;
                end else begin
                    bus.if_addr = ~addr;
                end
            end
        end
        chk("ready_seen", 32'(got), 32'(1));
        chk("latency", 32'(cyc), 32'(exp_cycles));
        @(posedge clk);
        #1;
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.if_addr = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    typedef struct {
        logic        side_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cycles;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        grant_t g;
        resp_t  r;
        bit     d_done, i_done;
        int     dcount;

        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state",     32'(dut.state_reg), 32'(IDLE));
        chk("rst_mem_req",   32'(bus.mem_req), 32'(0));
        chk("rst_mem_we",    32'(bus.mem_we), 32'(0));
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_ready",  32'(bus.if_ready), 32'(0));
        chk("rst_dm_ready",  32'(bus.dm_ready), 32'(0));
        chk("rst_if_rdata",  bus.if_rdata, 32'h0);
        chk("rst_dm_rdata",  bus.dm_rdata, 32'h0);
        chk("rst_err",       32'(err), 32'(0));
        chk("rst_starve",    32'(dut.starve_cnt_reg), 32'(0));
        chk("rst_timer",     32'(dut.u_timer.count_reg), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // side_d, we, addr, wdata, ack latency, request-to-ready cycles, rdata
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 2, 5, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 3, mem_word(32'h0000_0100)};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 1, 4, 32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 3, 6, mem_word(32'hFFFF_FFFC)};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 0, 3, mem_word(32'h0000_0020)};
        vecs[5] = '{1'b1, 1'b1, 32'hABCD_0000, 32'hCAFE_F00D, 5, 8, 32'h0000_0000};

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].side_d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].lat, vecs[i].exp_cycles, vecs[i].exp_rdata, 1'b1);
        end

        // Both requesters at once: data write first, then fetch.
        ack_enable = 1'b1;
        ack_lat    = 1;
        g = '{1'b1, 32'h20, 32'h55};            grant_q.push_back(g);
        g = '{1'b0, 32'h200, 32'h0};            grant_q.push_back(g);
        r = '{1'b1, 32'h0};                     resp_q.push_back(r);
        r = '{1'b0, mem_word(32'h200)};         resp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h55;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        d_done = 1'b0;
        i_done = 1'b0;
        for (int c = 0; c < 60 && !i_done; c++) begin
            @(negedge clk);
            if (!bus.if_ready) chk("stall_if_held", 32'(c_stall_if), 32'(1));
            if (bus.dm_ready) d_done = 1'b1;
            if (bus.if_ready) begin
                i_done = 1'b1;
                chk("dm_before_if", 32'(d_done), 32'(1));
            end
            @(posedge clk);
            #1;
            if (d_done) bus.dm_req = 1'b0;
            if (i_done) bus.if_req = 1'b0;
        end
        chk("both_served", 32'(d_done & i_done), 32'(1));
        bus.dm_we = 1'b0;

        // Continuous data traffic with fetch waiting: four data wins, then fetch.
        ack_lat = 0;
        for (int k = 0; k < 4; k++) begin
            g = '{1'b0, 32'h40, 32'h0};         grant_q.push_back(g);
            r = '{1'b1, mem_word(32'h40)};      resp_q.push_back(r);
        end
        g = '{1'b0, 32'h300, 32'h0};            grant_q.push_back(g);
        r = '{1'b0, mem_word(32'h300)};         resp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        dcount = 0;
        i_done = 1'b0;
        for (int c = 0; c < 100 && !i_done; c++) begin
            @(negedge clk);
            if (bus.dm_ready) begin
                dcount++;
                if (dcount == 4) chk("starve_at_max", 32'(dut.starve_cnt_reg), 32'(4));
            end
            if (bus.if_ready) begin
                i_done = 1'b1;
                chk("fetch_after_4", 32'(dcount), 32'(4));
                chk("starve_cleared", 32'(dut.starve_cnt_reg), 32'(0));
            end
            @(posedge clk);
            #1;
            if (i_done) begin
                bus.dm_req = 1'b0;
                bus.if_req = 1'b0;
            end
        end
        chk("fetch_served", 32'(i_done), 32'(1));

        // No ack: 16 BUSY cycles, zero data, sticky err.
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 0, 18, 32'h0, 1'b0);
        chk("err_set", 32'(err), 32'(1));
        chk("timeout_mem_req_low", 32'(bus.mem_req), 32'(0));
        do_req(1'b0, 1'b0, 32'h44, 32'h0, 1, 4, mem_word(32'h44), 1'b1);
        chk("err_sticky", 32'(err), 32'(1));
        chk("queues_drained_mid", 32'(grant_q.size() + resp_q.size()), 32'(0));

        // Reset in the middle of a data access.
        ack_enable = 1'b0;
        g = '{1'b0, 32'h44, 32'h0};             grant_q.push_back(g);
        @(posedge clk);
        #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h44; bus.dm_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_d_before_rst", 32'(dut.state_reg), 32'(BUSY_D));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("rst_busy_mem_req", 32'(bus.mem_req), 32'(0));
        chk("rst_busy_state", 32'(dut.state_reg), 32'(IDLE));
        chk("rst_busy_err", 32'(err), 32'(0));
        for (int c = 0; c < 4; c++) begin
            chk("rst_busy_no_ready", 32'(bus.dm_ready), 32'(0));
            @(negedge clk);
        end

        // Stray ack while idle.
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_state", 32'(dut.state_reg), 32'(IDLE));
        chk("stray_mem_req", 32'(bus.mem_req), 32'(0));
        chk("stray_ready", 32'(bus.if_ready | bus.dm_ready), 32'(0));
        chk("stray_rdata", bus.if_rdata | bus.dm_rdata, 32'h0);

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(grant_q.size() + resp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width for both requesters and the memory port.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, consecutive data-side wins after which a pending fetch is forced through.
REQ-004 Parameter TIMEOUT, 16, cycles in a BUSY state without mem_ack before the transaction is aborted.
REQ-005 Port list: one clock; reset is synchronous and active-low. Ports are:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  instruction-fetch request, level, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_W  fetched word, valid while if_ready=1.
- dm_req  in  1  data request, level, held until dm_ready.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ready  out  1  one-cycle completion pulse to data side.
- dm_rdata  out  DATA_W  read word, valid while dm_ready=1.
- mem_req  out  1  request to the single-port memory, registered.
- mem_we  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- c_stall_if  out  1  fetch-stage stall.
- c_stall_mem  out  1  MEM-stage stall.
- err  out  1  sticky timeout flag.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY_I, BUSY_D and RESP.
REQ-007 In IDLE with dm_req=1, the FSM SHALL go to BUSY_D, unless if_req=1 and starve_cnt==STARVE_MAX, in which case it SHALL go to BUSY_I.
REQ-008 In IDLE with only if_req=1, the FSM SHALL go to BUSY_I; with no requests, it SHALL stay in IDLE.
REQ-009 On the grant edge, the block SHALL latch the granted address, we and wdata, and assert mem_req from the next cycle; if_we is always 0.
REQ-010 mem_req SHALL stay high through BUSY_x and drop on the edge after mem_ack is seen.
REQ-011 mem_ack received in BUSY_x SHALL capture mem_rdata and move the FSM to RESP, which lasts exactly one cycle and then returns to IDLE.
REQ-012 In RESP, exactly one of if_ready/dm_ready SHALL be 1, for the granted side, with the matching rdata driven; rdata is 0 for writes.
REQ-013 Latency SHALL be: request sampled in IDLE at edge N, mem_req=1 in cycle N+1; mem_ack at edge M, ready=1 in cycle M+1; minimum request-to-ready is 3 cycles.
REQ-014 starve_cnt (clog2(STARVE_MAX+1) bits) SHALL increment, saturating at STARVE_MAX, on each IDLE->BUSY_D transition taken while if_req=1, and SHALL clear on IDLE->BUSY_I.
REQ-015 A per-transaction timer SHALL count cycles in BUSY_x; when it reaches TIMEOUT without ack, the FSM SHALL go to RESP with rdata=0, set err, and drop mem_req.
REQ-016 mem_ack seen in IDLE or RESP SHALL be ignored.
REQ-017 c_stall_if SHALL equal if_req & ~if_ready, and c_stall_mem SHALL equal dm_req & ~dm_ready; both are combinational.
REQ-018 Requester inputs changing while that side is granted SHALL NOT affect the latched transaction.

Reset
REQ-019 When rst_n=0 at a rising edge, the block SHALL enter IDLE and set mem_req, mem_we, if_ready, dm_ready and err to 0, mem_addr, mem_wdata and both rdata outputs to 0, and starve_cnt and the timer to 0.
REQ-020 Reset during BUSY_x SHALL abandon the transaction: no ready pulse, and mem_req=0 the cycle after the reset edge.

Structure
REQ-021 The state encoding and the default TIMEOUT/STARVE_MAX SHALL live in shared package mem_pkg.
REQ-022 The block SHALL contain one sub-module, arb_timer (a loadable up-counter with terminal flag), instantiated for the timeout.

Verification
REQ-023 Directed: dm read only, addr=0x10, ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> dm_ready in cycle 5 with dm_rdata=0xDEADBEEF, mem_we=0.
REQ-024 Directed: if_req and dm_req (write 0x55 to 0x20) held from cycle 0 -> data write served first, fetch served next; c_stall_if stays high until if_ready.
REQ-025 Directed: dm_req held continuously with if_req=1 and immediate acks -> 4 data grants, then the 5th grant goes to fetch and starve_cnt returns to 0.
REQ-026 Directed: mem_ack never asserted -> ready pulse with rdata=0 after 16 BUSY cycles, err=1 until reset.
REQ-027 Directed: rst_n=0 for one edge while in BUSY_D -> no dm_ready, mem_req=0 the next cycle, FSM in IDLE.
REQ-028 Directed: stray mem_ack in IDLE -> no ready pulse and no state change.
